// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: state encoding, dac_ctrl bit map and helpers shared by the burst sequencer.
package tx_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAKE     = 3'd1,
        S_SETTLE   = 3'd2,
        S_STREAM   = 3'd3,
        S_TAIL     = 3'd4,
        S_SHUTDOWN = 3'd5
    } state_t;

    localparam int DAC_WAKE = 0;
    localparam int PA_EN    = 1;
    localparam int RUN      = 2;
    localparam int TEST     = 3;

    // DAC stays awake through SHUTDOWN so the PA always drops first.
    function automatic logic [3:0] ctrl_of(input state_t s);
        logic [3:0] c;
        c = 4'b0000;
        c[DAC_WAKE] = s != S_IDLE;
        c[PA_EN]    = s == S_SETTLE || s == S_STREAM || s == S_TAIL;
        c[RUN]      = s == S_STREAM;
        c[TEST]     = 1'b0;
        return c;
    endfunction

    // Wait counter width: enough bits to count 0 .. max(a,b,c)-1, never less than one.
    function automatic int wait_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > 1 ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/tx_seq_gate.sv
// tx_seq_gate: combinational AXIS gate with the burst beat counter and terminal-count compare.
module tx_seq_gate #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             open,
    input  logic             clear,
    input  logic [CNT_W-1:0] len,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    input  logic             m_tready,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    output logic             s_tready,
    output logic             term,
    output logic             last
);

    logic [CNT_W-1:0] cnt;
    logic             beat;

    assign m_tdata  = s_tdata;
    assign m_tvalid = open & s_tvalid;
    assign s_tready = open & m_tready;
    assign beat     = m_tvalid & m_tready;
    assign term     = beat && CNT_W'(cnt + 1'b1) == len;
    assign last     = beat & s_tlast;

    // Beat counter: cleared by an accepted start, advanced by each transferred sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (beat)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/tx_burst_sequencer.sv
// tx_burst_sequencer: wakes the DAC, enables the PA, gates burst_len samples, then shuts down PA-first.
// Optional: define TX_SEQ_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module tx_burst_sequencer
    import tx_seq_pkg::*;
#(
    parameter int WAKE_CYCLES = 100,
    parameter int PA_SETTLE   = 50,
    parameter int TAIL_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             s00_axis_aclk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [3:0]       dac_ctrl,
    output logic             busy,
    output logic             done,
    output logic             short_burst,
    output logic [2:0]       state
`ifdef TX_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0]      underrun_cnt
`endif
);

    localparam int WW = wait_width(WAKE_CYCLES, PA_SETTLE, TAIL_CYCLES);

    state_t           st, nxt;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] len_q;
    logic             go, active, term, last, early;

    assign go     = st == S_IDLE && start && burst_len != '0;
    assign active = st inside {S_WAKE, S_SETTLE, S_STREAM, S_TAIL};
    assign early  = !term && ((abort && active) || last);
    assign state  = st;

    tx_seq_gate #(.CNT_W(CNT_W)) u_gate (
        .clk      (s00_axis_aclk),
        .rst      (reset),
        .open     (st == S_STREAM),
        .clear    (go),
        .len      (len_q),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .s_tready (s_tready),
        .term     (term),
        .last     (last)
    );

    // Next-state decode; abort overrides every exit but never blocks a beat already on the bus.
    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:     nxt = go ? S_WAKE : S_IDLE;
            S_WAKE:     nxt = abort ? S_SHUTDOWN : wait_cnt == WW'(WAKE_CYCLES - 1) ? S_SETTLE : S_WAKE;
            S_SETTLE:   nxt = abort ? S_SHUTDOWN : wait_cnt == WW'(PA_SETTLE - 1) ? S_STREAM : S_SETTLE;
            S_STREAM:   nxt = abort ? S_SHUTDOWN : (term || last) ? S_TAIL : S_STREAM;
            S_TAIL:     nxt = abort ? S_SHUTDOWN : wait_cnt == WW'(TAIL_CYCLES - 1) ? S_SHUTDOWN : S_TAIL;
            S_SHUTDOWN: nxt = S_IDLE;
            default:    nxt = S_SHUTDOWN;
        endcase
    end

    // State register with outputs registered from the state being entered.
    always_ff @(posedge s00_axis_aclk or posedge reset) begin
        if (reset) begin
            st          <= S_IDLE;
            wait_cnt    <= '0;
            len_q       <= '0;
            dac_ctrl    <= 4'b0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_burst <= 1'b0;
        end else begin
            st          <= nxt;
            wait_cnt    <= nxt != st ? '0 : wait_cnt + 1'b1;
            len_q       <= go ? burst_len : len_q;
            dac_ctrl    <= ctrl_of(nxt);
            busy        <= nxt != S_IDLE;
            done        <= st == S_SHUTDOWN;
            short_burst <= go ? 1'b0 : short_burst | early;
        end
    end

`ifdef TX_SEQ_UNDERRUN_CNT_EN
    logic seen;

    // Underrun: DAC ready but source idle, counted only once the burst has moved its first sample.
    always_ff @(posedge s00_axis_aclk or posedge reset) begin
        if (reset) begin
            seen         <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            seen         <= go ? 1'b0 : seen | (m_tvalid & m_tready);
            underrun_cnt <= go ? '0 :
                            (st == S_STREAM && seen && m_tready && !s_tvalid && underrun_cnt != 16'hFFFF) ?
                            underrun_cnt + 1'b1 : underrun_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// tb_tx_burst_sequencer: randomized self-checking bench for tx_burst_sequencer.
module tb_tx_burst_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, s_tvalid, s_tlast, m_tready;
    logic        s_tready, m_tvalid, busy, done, short_burst;
    logic [15:0] burst_len;
    logic [31:0] s_tdata, m_tdata;
    logic [3:0]  dac_ctrl;
    logic [2:0]  state;
`ifdef TX_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int src_idx = 0;
    int tlast_idx = 0;
    bit tlast_en = 1'b0;

    logic [31:0] src_mem [0:4095];
    logic [3:0]  ctrl_hist [0:65535];
    logic [31:0] beat_q [$];
    int          beat_cyc [$];
    int          done_cyc [$];

    always #10 clk = ~clk;

    assign s_tdata = src_mem[src_idx[11:0]];
    assign s_tlast = tlast_en && src_idx == tlast_idx;

    tx_burst_sequencer dut (
        .s00_axis_aclk (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .burst_len     (burst_len),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tlast       (s_tlast),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .dac_ctrl      (dac_ctrl),
        .busy          (busy),
        .done          (done),
        .short_burst   (short_burst),
        .state         (state)
`ifdef TX_SEQ_UNDERRUN_CNT_EN
        ,
        .underrun_cnt  (underrun_cnt)
`endif
    );

    // Cycle index and source pointer: the source offers the next sample after every accepted beat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_tvalid && s_tready)
            src_idx <= src_idx + 1;
    end

    // Monitor: log control word, beats and done pulses; PA never on with DAC asleep, stream only with RUN.
    always @(negedge clk) begin
        ctrl_hist[cyc[15:0]] = dac_ctrl;
        if (m_tvalid && m_tready) begin
            beat_q.push_back(m_tdata);
            beat_cyc.push_back(cyc);
        end
        if (done)
            done_cyc.push_back(cyc);
        if (!reset) begin
            checks++;
            if ((dac_ctrl[1] && !dac_ctrl[0]) || ((m_tvalid || s_tready) && !dac_ctrl[2])) begin
                errors++;
                $display("FAIL invariant cyc=%0d dac_ctrl=%b m_tvalid=%b s_tready=%b (PA needs DAC awake, stream needs RUN)",
                         cyc, dac_ctrl, m_tvalid, s_tready);
            end
        end
    end

    function automatic int exp_beats(input int len, input int tlast_at);
        return (tlast_at >= 0 && tlast_at < len) ? tlast_at + 1 : len;
    endfunction

    function automatic bit exp_short(input int len, input int tlast_at);
        return tlast_at >= 0 && tlast_at + 1 < len;
    endfunction

    // Drive one burst request and the handshake pattern until done, bounded by a cycle budget.
    task automatic run_burst(input int len, input int tlast_at, input int rdy_mode, input int vld_mode,
                             input int abort_at, input int restart_at,
                             output int t0, output int base, output bit to);
        @(posedge clk); #1;
        base = src_idx;
        tlast_idx = base + tlast_at;
        tlast_en = tlast_at >= 0;
        beat_q.delete();
        beat_cyc.delete();
        done_cyc.delete();
        burst_len = 16'(len);
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        to = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            start = restart_at >= 0 && cyc == t0 + restart_at;
            burst_len = 16'($urandom_range(1, 200));
            m_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? k[0] : 1'($urandom_range(0, 1));
            s_tvalid = vld_mode == 0 ? 1'b1 : vld_mode == 1 ? 1'($urandom_range(0, 1)) :
                       !(cyc >= t0 + 154 && cyc < t0 + 157);
            abort = abort_at >= 0 && cyc == t0 + abort_at;
            @(negedge clk); #1;
            if (done_cyc.size() != 0) begin
                to = 1'b0;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; burst_len = 16'd8; s_tvalid = 1'b1; m_tready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (dac_ctrl !== 4'b0000) begin errors++; $display("FAIL reset_dac_ctrl got %b want 0000", dac_ctrl); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (short_burst !== 1'b0) begin errors++; $display("FAIL reset_short got %b want 0", short_burst); end
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            errors++; $display("FAIL reset_gate got m_tvalid=%b s_tready=%b want 0 0", m_tvalid, s_tready); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || busy !== 1'b0 || state !== 3'd0) begin
            errors++; $display("FAIL idle_gate got m_tvalid=%b s_tready=%b busy=%b state=%0d want 0 0 0 0",
                               m_tvalid, s_tready, busy, state); end
    endtask

    task automatic test_full_burst;
        int t0, base;
        bit to;
        int at [9];
        logic [3:0] want [9];
        run_burst(8, -1, 0, 0, -1, -1, t0, base, to);
        at = '{t0 + 1, t0 + 100, t0 + 101, t0 + 150, t0 + 151, t0 + 159, t0 + 174, t0 + 175, t0 + 176};
        want = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0011, 4'b0011, 4'b0001, 4'b0000};
        checks++; if (to) begin errors++; $display("FAIL full_timeout no done within budget"); end
        checks++; if (beat_q.size() != 8) begin errors++; $display("FAIL full_beats got %0d want 8", beat_q.size()); end
        for (int i = 0; i < beat_q.size() && i < 8; i++) begin
            checks++;
            if (beat_q[i] !== src_mem[base + i] || beat_cyc[i] != t0 + 151 + i) begin
                errors++; $display("FAIL full_beat%0d got %h@%0d want %h@%0d", i, beat_q[i], beat_cyc[i] - t0,
                                   src_mem[base + i], 151 + i); end
        end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 176) begin
            errors++; $display("FAIL full_done got %0d pulses first@%0d want 1@176", done_cyc.size(),
                               done_cyc.size() ? done_cyc[0] - t0 : -1); end
        checks++; if (short_burst !== 1'b0) begin errors++; $display("FAIL full_short got %b want 0", short_burst); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ctrl_hist[16'(at[i])] !== want[i]) begin
                errors++; $display("FAIL full_ctrl@%0d got %b want %b", at[i] - t0, ctrl_hist[16'(at[i])], want[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b want 0", busy); end
    endtask

    task automatic test_tlast_early;
        int t0, base;
        bit to;
        run_burst(8, 4, 0, 0, -1, -1, t0, base, to);
        checks++; if (to || beat_q.size() != 5) begin
            errors++; $display("FAIL tlast_beats got %0d (timeout %b) want 5", beat_q.size(), to); end
        checks++; if (ctrl_hist[16'(t0 + 156)] !== 4'b0011 || ctrl_hist[16'(t0 + 171)] !== 4'b0011 ||
                      ctrl_hist[16'(t0 + 172)] !== 4'b0001) begin
            errors++; $display("FAIL tlast_tail got %b %b %b want 0011 0011 0001", ctrl_hist[16'(t0 + 156)],
                               ctrl_hist[16'(t0 + 171)], ctrl_hist[16'(t0 + 172)]); end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 173) begin
            errors++; $display("FAIL tlast_done got %0d pulses first@%0d want 1@173", done_cyc.size(),
                               done_cyc.size() ? done_cyc[0] - t0 : -1); end
        checks++; if (short_burst !== 1'b1) begin errors++; $display("FAIL tlast_short got %b want 1", short_burst); end
    endtask

    task automatic test_abort_settle;
        int t0, base;
        bit to;
        run_burst(8, -1, 0, 0, 120, -1, t0, base, to);
        checks++; if (to || beat_q.size() != 0) begin
            errors++; $display("FAIL abort_settle_beats got %0d (timeout %b) want 0", beat_q.size(), to); end
        checks++; if (ctrl_hist[16'(t0 + 120)] !== 4'b0011 || ctrl_hist[16'(t0 + 121)] !== 4'b0001 ||
                      ctrl_hist[16'(t0 + 122)] !== 4'b0000) begin
            errors++; $display("FAIL abort_settle_ctrl got %b %b %b want 0011 0001 0000", ctrl_hist[16'(t0 + 120)],
                               ctrl_hist[16'(t0 + 121)], ctrl_hist[16'(t0 + 122)]); end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 122) begin
            errors++; $display("FAIL abort_settle_done got %0d pulses first@%0d want 1@122", done_cyc.size(),
                               done_cyc.size() ? done_cyc[0] - t0 : -1); end
        checks++; if (short_burst !== 1'b1) begin errors++; $display("FAIL abort_settle_short got %b want 1", short_burst); end
    endtask

    task automatic test_abort_stream;
        int t0, base;
        bit to;
        for (int pass = 0; pass < 2; pass++) begin
            run_burst(pass == 0 ? 8 : 3, -1, 0, 0, 153, -1, t0, base, to);
            checks++; if (to || beat_q.size() != 3) begin
                errors++; $display("FAIL abort_stream%0d_beats got %0d (timeout %b) want 3", pass, beat_q.size(), to); end
            checks++; if (ctrl_hist[16'(t0 + 154)] !== 4'b0001 || done_cyc.size() != 1 || done_cyc[0] != t0 + 155) begin
                errors++; $display("FAIL abort_stream%0d_shutdown got ctrl %b done@%0d want 0001 done@155", pass,
                                   ctrl_hist[16'(t0 + 154)], done_cyc.size() ? done_cyc[0] - t0 : -1); end
            checks++; if (short_burst !== (pass == 0)) begin
                errors++; $display("FAIL abort_stream%0d_short got %b want %0d", pass, short_burst, pass == 0); end
        end
    endtask

    task automatic test_toggle_ready;
        int t0, base;
        bit to;
        run_burst(4, -1, 1, 1, -1, -1, t0, base, to);
        checks++; if (to || beat_q.size() != 4) begin
            errors++; $display("FAIL toggle_beats got %0d (timeout %b) want 4", beat_q.size(), to); end
        for (int i = 0; i < beat_q.size() && i < 4; i++) begin
            checks++;
            if (beat_q[i] !== src_mem[base + i] || beat_cyc[i] < t0 + 151) begin
                errors++; $display("FAIL toggle_beat%0d got %h@%0d want %h@>=151", i, beat_q[i], beat_cyc[i] - t0,
                                   src_mem[base + i]); end
        end
        checks++; if (beat_cyc.size() == 0 || done_cyc.size() != 1 || done_cyc[0] != beat_cyc[$] + 18) begin
            errors++; $display("FAIL toggle_done got %0d pulses, want one 18 cycles after last beat", done_cyc.size()); end
        checks++; if (short_burst !== 1'b0) begin errors++; $display("FAIL toggle_short got %b want 0", short_burst); end
    endtask

    task automatic test_ignored;
        int t0, base;
        bit to;
        done_cyc.delete();
        @(posedge clk); #1 burst_len = 16'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || state !== 3'd0 || done_cyc.size() != 0) begin
            errors++; $display("FAIL zero_len got busy=%b state=%0d done_pulses=%0d want 0 0 0", busy, state,
                               done_cyc.size()); end
        run_burst(2, -1, 0, 0, -1, 60, t0, base, to);
        repeat (10) @(negedge clk);
        checks++; if (to || beat_q.size() != 2) begin
            errors++; $display("FAIL start_busy_beats got %0d (timeout %b) want 2", beat_q.size(), to); end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 170 || busy !== 1'b0) begin
            errors++; $display("FAIL start_busy_done got %0d pulses first@%0d busy=%b want 1@170 busy=0",
                               done_cyc.size(), done_cyc.size() ? done_cyc[0] - t0 : -1, busy); end
    endtask

    task automatic test_gap;
        int t0, base;
        bit to;
        run_burst(8, -1, 0, 2, -1, -1, t0, base, to);
        checks++; if (to || beat_q.size() != 8) begin
            errors++; $display("FAIL gap_beats got %0d (timeout %b) want 8", beat_q.size(), to); end
        checks++; if (beat_cyc.size() < 4 || beat_cyc[3] != t0 + 157 || beat_q[3] !== src_mem[base + 3]) begin
            errors++; $display("FAIL gap_resume got beat3@%0d want @157 with source sample 3",
                               beat_cyc.size() > 3 ? beat_cyc[3] - t0 : -1); end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != t0 + 179) begin
            errors++; $display("FAIL gap_done got first@%0d want @179", done_cyc.size() ? done_cyc[0] - t0 : -1); end
`ifdef TX_SEQ_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'd3) begin
            errors++; $display("FAIL underrun_gap got %0d want 3", underrun_cnt); end
        run_burst(2, -1, 0, 0, -1, -1, t0, base, to);
        checks++; if (underrun_cnt !== 16'd0) begin
            errors++; $display("FAIL underrun_clear got %0d want 0", underrun_cnt); end
`endif
    endtask

    task automatic test_random;
        int t0, base, len, tl, n;
        bit to, sh;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 12);
            tl = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, len + 1));
            n = exp_beats(len, tl);
            sh = exp_short(len, tl);
            run_burst(len, tl, 2, 1, -1, -1, t0, base, to);
            checks++; if (to || beat_q.size() != n) begin
                errors++; $display("FAIL rand%0d_beats len=%0d tlast=%0d got %0d (timeout %b) want %0d", r, len, tl,
                                   beat_q.size(), to, n); end
            for (int i = 0; i < beat_q.size() && i < n; i++) begin
                checks++;
                if (beat_q[i] !== src_mem[base + i] || beat_cyc[i] < t0 + 151) begin
                    errors++; $display("FAIL rand%0d_beat%0d got %h@%0d want %h@>=151", r, i, beat_q[i],
                                       beat_cyc[i] - t0, src_mem[base + i]); end
            end
            checks++; if (beat_cyc.size() == 0 || done_cyc.size() != 1 || done_cyc[0] != beat_cyc[$] + 18) begin
                errors++; $display("FAIL rand%0d_done got %0d pulses, want one 18 cycles after last beat", r,
                                   done_cyc.size()); end
            checks++; if (short_burst !== sh) begin
                errors++; $display("FAIL rand%0d_short got %b want %b", r, short_burst, sh); end
        end
    endtask

    task automatic test_reset_mid_stream;
        @(posedge clk); #1 burst_len = 16'd20; start = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (155) @(posedge clk);
        #1;
        checks++; if (dac_ctrl !== 4'b0111) begin errors++; $display("FAIL mid_stream_ctrl got %b want 0111", dac_ctrl); end
        #2 reset = 1'b1;
        #1;
        checks++; if (dac_ctrl !== 4'b0000 || busy !== 1'b0 || state !== 3'd0) begin
            errors++; $display("FAIL async_reset got ctrl=%b busy=%b state=%0d want 0000 0 0", dac_ctrl, busy, state); end
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            errors++; $display("FAIL async_reset_gate got m_tvalid=%b s_tready=%b want 0 0", m_tvalid, s_tready); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            src_mem[i] = $urandom;
        test_reset;
        test_full_burst;
        test_tlast_early;
        test_abort_settle;
        test_abort_stream;
        test_toggle_ready;
        test_ignored;
        test_gap;
        test_random;
        test_reset_mid_stream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/tx_burst_sequencer.md
# tx_burst_sequencer

Controller that sequences one transmit burst through the AXI-Stream-to-AD9764 DAC block. It wakes the DAC and then enables the power amplifier. It gates exactly `burst_len` samples from the modem stream into the DAC block, holds a tail period, and shuts the PA and DAC down again. It sits between the OFDM sample source and the DAC slave, and drives that block's `control` port.

## Interface
Parameters:
- `WAKE_CYCLES`, 100: cycles from DAC wake to PA enable (2 us at 50 MHz).
- `PA_SETTLE`, 50: cycles from PA enable to stream open.
- `TAIL_CYCLES`, 16: cycles after the last sample before PA off.
- `CNT_W`, 16: width of the burst-length and sample counters.

Ports:
- `s00_axis_aclk`, in, 1: sole clock, 50 MHz max.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle burst request, sampled in IDLE only.
- `abort`, in, 1: level; forces an orderly shutdown from any active state.
- `burst_len`, in, CNT_W: sample count, latched on an accepted `start`.
- `s_tdata`, in, 32: upstream sample.
- `s_tvalid`, in, 1: upstream valid.
- `s_tready`, out, 1: upstream ready.
- `s_tlast`, in, 1: upstream end-of-frame.
- `m_tdata`, out, 32: sample to the DAC block.
- `m_tvalid`, out, 1: valid to the DAC block.
- `m_tready`, in, 1: ready from the DAC block.
- `dac_ctrl`, out, 4: drives the DAC block `control` port.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse on return to IDLE.
- `short_burst`, out, 1: sticky; set when the burst ended early by `s_tlast` or `abort`; cleared on the next accepted `start`.
- `state`, out, 3: current FSM state, for debug.

## Operation
- FSM encoding: IDLE=0, WAKE=1, SETTLE=2, STREAM=3, TAIL=4, SHUTDOWN=5. Codes 6 and 7 are illegal and go to SHUTDOWN.
- **IDLE:**
  - `start`=1 with `burst_len`≠0 latches the length, clears the counters and moves to WAKE.
  - `start` with `burst_len`=0 is ignored: no `done` pulse, no state change.
- **WAKE:** DAC_WAKE=1. Wait counter runs `WAKE_CYCLES` cycles, then go to SETTLE.
- **SETTLE:** DAC_WAKE=1 and PA_EN=1. Wait `PA_SETTLE` cycles, then go to STREAM.
- **STREAM:** DAC_WAKE=1, PA_EN=1 and RUN=1. The stream is gated open:
  - `m_tvalid` = `s_tvalid`.
  - `s_tready` = `m_tready`.
  - `m_tdata` = `s_tdata` (combinational).
  - Every beat with `m_tvalid`&`m_tready` increments the sample counter.
- **Leaving STREAM:**
  - Go to TAIL on the beat where the counter reaches the latched length.
  - Also go to TAIL on an accepted beat carrying `s_tlast`=1 before the length is reached; this sets `short_burst`.
- **TAIL:** RUN=0 and the stream is closed. PA and DAC stay enabled for `TAIL_CYCLES` cycles, then go to SHUTDOWN.
- **SHUTDOWN:** PA_EN=0 while DAC_WAKE=1 for one cycle, then go to IDLE with `done`=1 in that IDLE cycle. The PA is always off before the DAC sleeps.
- **abort:**
  - In WAKE, SETTLE, STREAM or TAIL, go to SHUTDOWN on the next edge and set `short_burst`.
  - Ignored in IDLE and SHUTDOWN.
- **Outside STREAM:** `m_tvalid`=0 and `s_tready`=0, regardless of the handshake inputs.
- **Simultaneous `abort` and the final beat:** the beat is transferred and counted, `abort` wins and the next state is SHUTDOWN. `short_burst` is not set, because the count was reached.
- **Wait counter:** shared by all timed states, width clog2 of the maximum parameter; reloaded on every state entry.

## Timing
- **Reset values:** state=IDLE, `dac_ctrl`=4'b0000, `busy`=0, `done`=0, `short_burst`=0, `m_tvalid`=0, `s_tready`=0, all counters 0.
- `dac_ctrl` and `busy` are registered and change on the edge that enters a state.
- Latency from `start` to the first possible stream beat = 1 + `WAKE_CYCLES` + `PA_SETTLE` cycles.
- The last accepted beat is followed by exactly `TAIL_CYCLES` cycles with PA on, then one SHUTDOWN cycle, then `done`.
- A reset asserted mid-burst clears everything immediately (asynchronous), including PA_EN.

## Configuration
- `TX_SEQ_UNDERRUN_CNT_EN` defined:
  - Adds output `underrun_cnt`, 16 bits, saturating.
  - It counts STREAM cycles after the first accepted beat where `m_tready`=1 and `s_tvalid`=0.
  - It is cleared on an accepted `start`.
- Not defined: the port and its logic are absent.

## Structure
- Shared package `tx_seq_pkg`:
  - State enum and its 3-bit encoding.
  - `dac_ctrl` bit positions: bit0 DAC_WAKE, bit1 PA_EN, bit2 RUN, bit3 TEST (tied to 0 here).
- One sub-module, `tx_seq_gate`: the combinational AXIS gate plus the beat counter and terminal-count compare.

## Test plan
- `burst_len`=8 with a continuous source and `m_tready`=1 → exactly 8 beats, first beat 151 cycles after `start`, `done` 18 cycles after the last beat, `short_burst`=0.
- `burst_len`=8 with `s_tlast` on beat 5 → 5 beats, TAIL entered, `short_burst`=1.
- `abort` raised in SETTLE → SHUTDOWN next cycle, PA_EN=0, zero beats, `done` pulse, `short_burst`=1.
- `m_tready` toggling every other cycle with `burst_len`=4 → 4 beats, no beat lost or duplicated, `m_tdata` matches the source sequence.
- `start` with `burst_len`=0, and `start` while `busy` → both ignored, no `done` pulse.
- With `TX_SEQ_UNDERRUN_CNT_EN`, a 3-cycle `s_tvalid` gap mid-burst → `underrun_cnt`=3; reset mid-STREAM → `dac_ctrl`=0 in the same cycle.
